// File: rtl/branch_predictor_pkg.sv
// Shared encodings, entry layout and PC field extraction for the branch predictor.
package branch_predictor_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_TAG_W = 8;
  localparam int unsigned DEF_CTR_W = 2;

  // Reference entry layout at the default geometry; the top declares the same shape for its widths.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0]  target;
    logic [DEF_CTR_W-1:0] ctr;
  } bp_entry_t;

  // Weakly-taken encoding: MSB set, all other bits clear.
  function automatic int unsigned ctr_wt(input int unsigned ctr_w);
    return 32'(1) << (ctr_w - 1);
  endfunction

  // Weakly-not-taken encoding: one below weakly-taken.
  function automatic int unsigned ctr_wnt(input int unsigned ctr_w);
    return ctr_wt(ctr_w) - 32'(1);
  endfunction

  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int unsigned lsb,
                                           input int unsigned w);
    return (pc >> lsb) & ((64'(1) << w) - 64'(1));
  endfunction

  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return pc_field(pc, 2, idx_w);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    return pc_field(pc, idx_w + 2, tag_w);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down step; holds at all-ones and at zero.
module branch_predictor_sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt_c
);

  always_comb begin
    nxt_c = val;
    if (inc && !dec && (val != {W{1'b1}})) begin
      nxt_c = val + W'(1);
    end else if (dec && !inc && (val != '0)) begin
      nxt_c = val - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, misprediction flag
// and saturating performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned CTR_W   = DEF_CTR_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             clear_i,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_entry;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CTR_W-1:0] ctr_nxt;

  logic [CNT_W-1:0] branch_cnt_nxt;
  logic [CNT_W-1:0] mispred_cnt_nxt;

  // Zero-latency lookup; reads the pre-update table state
  always_comb begin
    lk_idx          = IDX_W'(pc_index(64'(if_pc_i), IDX_W));
    lk_tag          = TAG_W'(pc_tag(64'(if_pc_i), IDX_W, TAG_W));
    lk_entry.valid  = valid_q[lk_idx];
    lk_entry.tag    = tag_q[lk_idx];
    lk_entry.target = target_q[lk_idx];
    lk_entry.ctr    = ctr_q[lk_idx];
    lk_hit          = lk_entry.valid && (lk_entry.tag == lk_tag);
    pred_taken_o    = lk_hit && lk_entry.ctr[CTR_W-1];
    pred_target_o   = pred_taken_o ? lk_entry.target : if_pc_i + XLEN'(4);
  end

  always_comb begin
    up_idx = IDX_W'(pc_index(64'(upd_pc_i), IDX_W));
    up_tag = TAG_W'(pc_tag(64'(upd_pc_i), IDX_W, TAG_W));
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  assign mispredict_o = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  branch_predictor_sat_counter #(.W(CTR_W)) u_dir_ctr (
    .val   (ctr_q[up_idx]),
    .inc   (upd_taken_i),
    .dec   (!upd_taken_i),
    .nxt_c (ctr_nxt)
  );

  branch_predictor_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .val   (branch_cnt_o),
    .inc   (upd_valid_i),
    .dec   (1'b0),
    .nxt_c (branch_cnt_nxt)
  );

  branch_predictor_sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .val   (mispred_cnt_o),
    .inc   (mispredict_o),
    .dec   (1'b0),
    .nxt_c (mispred_cnt_nxt)
  );

  // Valid bits and direction counters; clear overrides any same-cycle update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (clear_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_nxt;
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= WT;
      end
    end
  end

  // Tag/target payload is masked by valid, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (!clear_i && upd_valid_i && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      branch_cnt_o  <= branch_cnt_nxt;
      mispred_cnt_o <= mispred_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor at default geometry with hand-computed expectations.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        clear;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_predictor dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .if_pc_i           (if_pc),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .clear_i           (clear),
    .upd_valid_i       (upd_valid),
    .upd_pc_i          (upd_pc),
    .upd_taken_i       (upd_taken),
    .upd_target_i      (upd_target),
    .upd_pred_taken_i  (upd_pred_taken),
    .upd_pred_target_i (upd_pred_target),
    .mispredict_o      (mispredict),
    .branch_cnt_o      (branch_cnt),
    .mispred_cnt_o     (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an update on the falling edge; the caller samples mispredict before the commit.
  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    if_pc           = pc;
    #1;
  endtask

  task automatic commit_upd();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b0) begin
      bad++; $display("FAIL reset_taken got=%h want=0", pred_taken);
    end
    total++;
    if (pred_target !== 32'h104) begin
      bad++; $display("FAIL reset_target got=%h want=00000104", pred_target);
    end
    total++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnts got=%0d/%0d want=0/0", branch_cnt, mispred_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if_pc = 32'hFFFF_FFFC;
    #1;
    total++;
    if (pred_target !== 32'h0000_0000) begin
      bad++; $display("FAIL pc_wrap got=%h want=00000000", pred_target);
    end
  endtask

  task automatic test_allocate();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    total++;
    if (mispredict !== 1'b1) begin
      bad++; $display("FAIL alloc_mispredict got=%h want=1", mispredict);
    end
    commit_upd();
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      bad++; $display("FAIL alloc_lookup got=%h/%h want=1/00000080", pred_taken, pred_target);
    end
    total++;
    if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
      bad++; $display("FAIL alloc_cnts got=%0d/%0d want=1/1", branch_cnt, mispred_cnt);
    end
  endtask

  // Counter walk from WT: 2->1->0->0, then 1,2,3,3
  task automatic test_counter();
    logic       tk   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       ptk  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       emis [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       etk  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] etgt;
    for (int i = 0; i < 7; i++) begin
      drive_upd(32'h100, tk[i], 32'h80, ptk[i], ptk[i] ? 32'h80 : 32'h104);
      total++;
      if (mispredict !== emis[i]) begin
        bad++; $display("FAIL ctr_mispredict[%0d] got=%h want=%h", i, mispredict, emis[i]);
      end
      commit_upd();
      if_pc = 32'h100;
      #1;
      etgt = etk[i] ? 32'h80 : 32'h104;
      total++;
      if (pred_taken !== etk[i] || pred_target !== etgt) begin
        bad++; $display("FAIL ctr_lookup[%0d] got=%h/%h want=%h/%h", i, pred_taken, pred_target,
                        etk[i], etgt);
      end
    end
    total++;
    if (branch_cnt !== 32'd8 || mispred_cnt !== 32'd4) begin
      bad++; $display("FAIL ctr_cnts got=%0d/%0d want=8/4", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_alias();
    drive_upd(32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
    commit_upd();
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      bad++; $display("FAIL alias_old got=%h/%h want=0/00000104", pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      bad++; $display("FAIL alias_new got=%h/%h want=1/00000040", pred_taken, pred_target);
    end
    total++;
    if (branch_cnt !== 32'd9 || mispred_cnt !== 32'd5) begin
      bad++; $display("FAIL alias_cnts got=%0d/%0d want=9/5", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    commit_upd();
    drive_upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    total++;
    if (mispredict !== 1'b1) begin
      bad++; $display("FAIL rw_mispredict got=%h want=1", mispredict);
    end
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      bad++; $display("FAIL rw_same_cycle got=%h/%h want=1/00000080", pred_taken, pred_target);
    end
    commit_upd();
    #1;
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
      bad++; $display("FAIL rw_next_cycle got=%h/%h want=1/00000090", pred_taken, pred_target);
    end
    total++;
    if (branch_cnt !== 32'd11 || mispred_cnt !== 32'd7) begin
      bad++; $display("FAIL rw_cnts got=%0d/%0d want=11/7", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive_upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h104);
    total++;
    if (pred_taken !== 1'b1) begin
      bad++; $display("FAIL ar_before got=%h want=1", pred_taken);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      bad++; $display("FAIL ar_lookup got=%h/%h want=0/00000104", pred_taken, pred_target);
    end
    total++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      bad++; $display("FAIL ar_cnts got=%0d/%0d want=0/0", branch_cnt, mispred_cnt);
    end
    total++;
    if (mispredict !== 1'b1) begin
      bad++; $display("FAIL ar_mispredict got=%h want=1", mispredict);
    end
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n     = 1'b1;
    if_pc     = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      bad++; $display("FAIL ar_after_100 got=%h/%h want=0/00000104", pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      bad++; $display("FAIL ar_after_200 got=%h/%h want=0/00000204", pred_taken, pred_target);
    end
    @(posedge clk);
    #1;
    total++;
    if (branch_cnt !== 32'd0) begin
      bad++; $display("FAIL ar_idle_cnt got=%0d want=0", branch_cnt);
    end
  endtask

  task automatic test_clear();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    commit_upd();
    drive_upd(32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
    clear = 1'b1;
    commit_upd();
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      bad++; $display("FAIL clr_100 got=%h/%h want=0/00000104", pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      bad++; $display("FAIL clr_200 got=%h/%h want=0/00000204", pred_taken, pred_target);
    end
    total++;
    if (branch_cnt !== 32'd2 || mispred_cnt !== 32'd2) begin
      bad++; $display("FAIL clr_cnts got=%0d/%0d want=2/2", branch_cnt, mispred_cnt);
    end
    // Cleared entry must come back at WT, not at a stale counter value
    drive_upd(32'h100, 1'b1, 32'h88, 1'b0, 32'h104);
    commit_upd();
    if_pc = 32'h100;
    #1;
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h88) begin
      bad++; $display("FAIL clr_realloc got=%h/%h want=1/00000088", pred_taken, pred_target);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    if_pc           = '0;
    clear           = 1'b0;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_back_to_back();
    test_async_reset();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
